// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI master controller: FSM state
//            encoding and default transfer geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default transfer width in bits and clk cycles per sclk half-period.
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 2;

  // Controller states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl_if
// Purpose  : Bundles the host handshake (start/tx_data/busy/done/rx_data) and
//            the SPI pins (sclk/cs_n/mosi/miso) of the SPI master controller.
// Modports : master - controller view (drives busy/done/rx_data/SPI outputs)
//            slave  - host/slave-side view (drives start/tx_data/miso)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_ctrl_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start,
    input  tx_data,
    input  miso,
    output busy,
    output done,
    output rx_data,
    output sclk,
    output cs_n,
    output mosi
  );

  modport slave (
    output start,
    output tx_data,
    output miso,
    input  busy,
    input  done,
    input  rx_data,
    input  sclk,
    input  cs_n,
    input  mosi
  );

endinterface : spi_master_ctrl_if
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Purpose  : Half-period tick generator. While enabled it counts CLK_DIV clk
//            cycles per phase and flags the last cycle of each phase; the
//            count wraps to 0 at every phase end and is held at 0 while
//            disabled, so every phase starts from a clean count.
// Ports    : clk       - system clock
//            reset     - synchronous active-low reset
//            enable    - count enable; low clears the counter
//            phase_end - high on the last cycle of the current phase
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase_end
);

  localparam int                 CNT_W  = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign phase_end = enable && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : SPI mode-0 master. Runs one DATA_W-bit full-duplex transfer per
//            accepted start: MSB-first on mosi, miso captured into rx_data,
//            one-cycle done pulse at the end. All outputs are registered.
// Ports    : clk   - system clock
//            reset - synchronous active-low reset
//            bus   - spi_master_ctrl_if.master (host handshake + SPI pins)
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_ctrl_if.master   bus
);

  localparam int               BIT_W      = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;

  logic              w_div_en;
  logic              w_phase_end;

  // Single-cycle strobes decoded from the FSM, consumed by the datapath.
  logic              w_accept;
  logic              w_enter_high;
  logic              w_enter_low;
  logic              w_finish;

  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_rx_data;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_sclk;
  logic              r_cs_n;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .enable    (w_div_en),
    .phase_end (w_phase_end)
  );

  // Divider runs only in the timed phases; IDLE/DONE hold it cleared.
  assign w_div_en = (r_state == ST_SETUP) || (r_state == ST_HIGH) ||
                    (r_state == ST_LOW);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_enter_high = 1'b0;
    w_enter_low  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_phase_end) begin
          w_enter_high = 1'b1;
          w_state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_enter_low  = 1'b1;
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        // The last LOW phase doubles as cs_n hold time before DONE.
        if (w_phase_end) begin
          if (r_bit_cnt == '0) begin
            w_finish     = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_enter_high = 1'b1;
            w_state_next = ST_HIGH;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_bit_cnt <= C_BIT_LAST;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_tx_sr   <= bus.tx_data;
        r_bit_cnt <= C_BIT_LAST;
        r_cs_n    <= 1'b0;
        r_busy    <= 1'b1;
        r_sclk    <= 1'b0;
      end

      // miso is sampled on the same edge that raises sclk.
      if (w_enter_high) begin
        r_sclk  <= 1'b1;
        r_rx_sr <= {r_rx_sr[DATA_W-2:0], bus.miso};
      end

      // Decrement only when looping LOW -> HIGH, so the counter reads 0
      // throughout the final bit.
      if (w_enter_high && (r_state == ST_LOW)) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end

      // mosi is the tx shift register MSB; advance it on the falling sclk
      // unless the final bit is on the wire.
      if (w_enter_low) begin
        r_sclk <= 1'b0;
        if (r_bit_cnt != '0) begin
          r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end
      end

      if (w_finish) begin
        r_cs_n    <= 1'b1;
        r_busy    <= 1'b0;
        r_sclk    <= 1'b0;
        r_done    <= 1'b1;
        r_rx_data <= r_rx_sr;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign bus.sclk    = r_sclk;
  assign bus.cs_n    = r_cs_n;
  assign bus.mosi    = r_tx_sr[DATA_W-1];

endmodule : spi_master_ctrl
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master controller that sequences one DATA_W-bit full-duplex transfer per request. It shifts the master byte out MSB-first on mosi and captures the slave byte on miso. It generates sclk (SPI mode 0: CPOL=0, CPHA=0) and cs_n, and exposes a start/busy/done handshake to the host logic. It sits between the SPI_Protocol host-side logic and the external slave shift register.

Parameters:
DATA_W, 8, transfer width in bits (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset; the block resets when reset==0 at a clk rising edge
start  input  1  transfer request, sampled only in IDLE
tx_data  input  DATA_W  byte to transmit, latched when start is accepted
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when rx_data is valid
rx_data  output  DATA_W  last received byte, held until the next done
sclk  output  1  SPI clock, idle low
cs_n  output  1  slave select, active low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, busy=0, done=0, rx_data=0, sclk=0, cs_n=1, mosi=0, bit counter=DATA_W-1, divider=0. Reset asserted mid-transfer aborts the transfer: no done pulse, rx_data is cleared, cs_n returns high on that edge.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE: when start==1 at edge T, latch tx_data into the shift register and enter SETUP. In cycle T+1: cs_n=0, busy=1, sclk=0, mosi=tx_data[DATA_W-1].
- SETUP: lasts CLK_DIV cycles, then goes to HIGH.
- HIGH: sclk=1 for CLK_DIV cycles. On the edge entering HIGH, sample miso into the rx shift register (shift left, LSB in).
- LOW: sclk=0 for CLK_DIV cycles.
  - On the edge entering LOW, if bits remain, mosi advances to the next lower bit.
  - At the end of LOW: if the bit counter is 0, go to DONE; otherwise decrement the counter and go to HIGH.
  - The final LOW phase serves as the cs_n hold time.
- DONE: lasts 1 cycle. cs_n=1, busy=0, sclk=0, done=1, rx_data=the captured byte. Next state is IDLE.
- Busy duration is exactly CLK_DIV*(1+2*DATA_W) cycles. With defaults that is 34 cycles (T+1..T+34), and done is high in cycle T+35.
- start is ignored while busy or in DONE; it is not queued. A start held high re-triggers at the first IDLE cycle after DONE.
- tx_data changes after acceptance have no effect on the transfer in progress.
- Divider counter width is clog2(CLK_DIV)+1 and wraps to 0 at each phase end. Bit counter width is clog2(DATA_W).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding constants ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_DONE (3 bits)
  - the default DATA_W and CLK_DIV
- One sub-module, spi_clk_div: a CLK_DIV half-period tick generator with an enable/clear input. It emits a phase_end pulse on the last cycle of each phase.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release -> busy=0, done=0, cs_n=1, sclk=0, mosi=0, rx_data=0x00.
- Basic exchange: tx_data=0x00, slave model returns 0xAB, pulse start -> 8 sclk rising edges, mosi stays 0, done in cycle T+35, rx_data=0xAB, cs_n low exactly 34 cycles.
- Bit order: tx_data=0x81, slave returns 0x5A, CLK_DIV=1 -> mosi sequence 1,0,0,0,0,0,0,1 at sclk rises, rx_data=0x5A, done at T+18.
- Start during busy: pulse start again at T+10 with tx_data=0xFF -> ignored, single done, second transfer does not start.
- Back-to-back: start held high continuously -> next cs_n fall occurs at T+37 (IDLE at T+36, accept, SETUP at T+37), rx_data updates on each done.
- Reset mid-transfer: assert reset=0 at T+12 -> next cycle cs_n=1, sclk=0, busy=0, no done pulse, rx_data=0x00, and a fresh start then completes normally.
